// File: rtl/m_pkg.sv
// Shared decode constants, M-extension func3 encodings and the issue FSM state type.
package m_pkg;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] Func7MulDiv = 7'b0000001;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } func3_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StResp  = 2'd3
  } issue_state_t;

  function automatic logic [6:0] get_ir_opcode(input logic [31:0] ir);
    return ir[6:0];
  endfunction

  function automatic logic [6:0] get_ir_func7(input logic [31:0] ir);
    return ir[31:25];
  endfunction

  function automatic logic [4:0] get_ir_rd(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic is_m_insn(input logic [31:0] ir);
    return (get_ir_opcode(ir) == OpcodeOp) && (get_ir_func7(ir) == Func7MulDiv);
  endfunction

endpackage

// File: rtl/m_pcpi_issue.sv
// Issue/stall adapter between EX and the PCPI M-extension unit.
// Optional watchdog on an unanswered request: define M_PCPI_TIMEOUT_EN.
module m_pcpi_issue
  import m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_instr_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  input  logic        ex_flush_i,
  output logic        stall_o,
  output logic [31:0] m_result_o,
  output logic        m_result_valid_o,
  output logic        m_we_o,
  output logic [4:0]  m_rd_o,
  output logic        pcpi_valid_o,
  output logic [31:0] pcpi_insn_o,
  output logic [31:0] pcpi_rs1_o,
  output logic [31:0] pcpi_rs2_o,
  input  logic        pcpi_wr_i,
  input  logic [31:0] pcpi_rd_i,
  input  logic        pcpi_ready_i,
  input  logic        pcpi_busy_i,
  output logic        timeout_o
);

  issue_state_t state_q, state_d;

  logic [31:0] insn_q, rs1_q, rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic [4:0]  m_rd_q;
  logic        we_q;
  logic        pcpi_valid_q;

  logic ex_is_m;
  logic start;
  logic wait_st;
  logic timeout_fire;
  logic resp_enter;

  assign ex_is_m = is_m_insn(ex_instr_i);
  assign start   = ex_valid_i && ex_is_m && !ex_flush_i;
  assign wait_st = (state_q == StIssue) || (state_q == StDrain);

  // Busy is informational only; sequencing relies on the ready pulse.
  logic unused_busy;
  assign unused_busy = pcpi_busy_i;

`ifdef M_PCPI_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       timeout_q;

  assign timeout_fire = wait_st && !pcpi_ready_i && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign timeout_o    = timeout_q;

  // Watchdog: counts cycles spent in ISSUE/DRAIN, restarting on every state entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (!wait_st || (state_d != state_q)) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo   = ^32'(TIMEOUT_CYCLES);
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  // Next-state decode; a ready pulse wins over a flush or a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StIssue;
      end
      StIssue: begin
        if (pcpi_ready_i || timeout_fire) begin
          state_d = ex_flush_i ? StIdle : StResp;
        end else if (ex_flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The unit cannot be aborted; wait for it to finish and drop the result.
        if (pcpi_ready_i || timeout_fire) state_d = StIdle;
      end
      StResp: begin
        // The M instruction still sitting in EX here is the one just completed.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign resp_enter = (state_q == StIssue) && (state_d == StResp);

  // FSM state plus all registered request/response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      result_q     <= '0;
      m_rd_q       <= '0;
      we_q         <= 1'b0;
      pcpi_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Request drops right after ready so the unit never sees a stale request.
      pcpi_valid_q <= (state_d == StIssue) || (state_d == StDrain);
      if ((state_q == StIdle) && start) begin
        insn_q <= ex_instr_i;
        rs1_q  <= ex_rs1_i;
        rs2_q  <= ex_rs2_i;
        rd_q   <= get_ir_rd(ex_instr_i);
      end
      if (resp_enter) begin
        m_rd_q <= rd_q;
        if (pcpi_ready_i) begin
          result_q <= pcpi_rd_i;
          we_q     <= pcpi_wr_i && (rd_q != '0);
        end else begin
          // Timed-out request: report a zero result without writing the register file.
          result_q <= '0;
          we_q     <= 1'b0;
        end
      end
    end
  end

  // Pipeline hold: only M instructions wait, everything else keeps flowing during a drain.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      StIdle:  stall_o = start;
      StIssue: stall_o = 1'b1;
      StDrain: stall_o = ex_valid_i && ex_is_m;
      StResp:  stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  assign m_result_valid_o = (state_q == StResp) && !ex_flush_i;
  assign m_we_o           = m_result_valid_o && we_q;
  assign m_result_o       = result_q;
  assign m_rd_o           = m_rd_q;
  assign pcpi_valid_o     = pcpi_valid_q;
  assign pcpi_insn_o      = insn_q;
  assign pcpi_rs1_o       = rs1_q;
  assign pcpi_rs2_o       = rs2_q;

endmodule

// File: tb/tb_m_pcpi_issue.sv
// Self-checking bench for m_pcpi_issue; the bench plays both EX and the M unit.
module tb_m_pcpi_issue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] ex_instr_i = '0;
  logic [31:0] ex_rs1_i = '0;
  logic [31:0] ex_rs2_i = '0;
  logic        ex_flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] m_result_o;
  logic        m_result_valid_o;
  logic        m_we_o;
  logic [4:0]  m_rd_o;
  logic        pcpi_valid_o;
  logic [31:0] pcpi_insn_o;
  logic [31:0] pcpi_rs1_o;
  logic [31:0] pcpi_rs2_o;
  logic        pcpi_wr_i = 1'b0;
  logic [31:0] pcpi_rd_i = '0;
  logic        pcpi_ready_i = 1'b0;
  logic        pcpi_busy_i = 1'b0;
  logic        timeout_o;

  m_pcpi_issue dut (
    .clk              (clk),
    .resetn           (resetn),
    .ex_valid_i       (ex_valid_i),
    .ex_instr_i       (ex_instr_i),
    .ex_rs1_i         (ex_rs1_i),
    .ex_rs2_i         (ex_rs2_i),
    .ex_flush_i       (ex_flush_i),
    .stall_o          (stall_o),
    .m_result_o       (m_result_o),
    .m_result_valid_o (m_result_valid_o),
    .m_we_o           (m_we_o),
    .m_rd_o           (m_rd_o),
    .pcpi_valid_o     (pcpi_valid_o),
    .pcpi_insn_o      (pcpi_insn_o),
    .pcpi_rs1_o       (pcpi_rs1_o),
    .pcpi_rs2_o       (pcpi_rs2_o),
    .pcpi_wr_i        (pcpi_wr_i),
    .pcpi_rd_i        (pcpi_rd_i),
    .pcpi_ready_i     (pcpi_ready_i),
    .pcpi_busy_i      (pcpi_busy_i),
    .timeout_o        (timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  logic prev_req = 1'b0;

  // Count distinct requests (rising edges of pcpi_valid_o), sampled mid-cycle.
  always @(negedge clk) begin
    if (pcpi_valid_o && !prev_req) req_cnt++;
    prev_req = pcpi_valid_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference RV32M arithmetic, from the ISA definition.
  function automatic logic [31:0] mext(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    logic signed [63:0] sa, sb, q;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_req"}, 32'(pcpi_valid_o), 32'd0);
    chk({tag, "_insn"}, pcpi_insn_o, 32'd0);
    chk({tag, "_rs1"}, pcpi_rs1_o, 32'd0);
    chk({tag, "_rs2"}, pcpi_rs2_o, 32'd0);
    chk({tag, "_res"}, m_result_o, 32'd0);
    chk({tag, "_rd"}, 32'(m_rd_o), 32'd0);
    chk({tag, "_rv"}, 32'(m_result_valid_o), 32'd0);
    chk({tag, "_we"}, 32'(m_we_o), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_o), 32'd0);
  endtask

  // Full transaction from IDLE: issue, unit answers after lat extra cycles, RESP.
  task automatic run_txn(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int lat,
                         input logic wr, input logic fl_resp);
    logic [31:0] ins, exp;
    ins = enc(7'b0000001, f3, rd);
    exp = mext(f3, a, b);
    ex_valid_i = 1'b1; ex_instr_i = ins; ex_rs1_i = a; ex_rs2_i = b; ex_flush_i = 1'b0;
    pcpi_ready_i = 1'b0;
    settle();
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "_idle_req"}, 32'(pcpi_valid_o), 32'd0);
    chk({tag, "_idle_rv"}, 32'(m_result_valid_o), 32'd0);
    step();
    for (int k = 0; k <= lat; k++) begin
      ex_rs1_i = $urandom;
      ex_rs2_i = $urandom;
      if (k == lat) begin
        pcpi_ready_i = 1'b1; pcpi_rd_i = exp; pcpi_wr_i = wr;
      end
      settle();
      chk({tag, "_iss_req"}, 32'(pcpi_valid_o), 32'd1);
      chk({tag, "_iss_insn"}, pcpi_insn_o, ins);
      chk({tag, "_iss_rs1"}, pcpi_rs1_o, a);
      chk({tag, "_iss_rs2"}, pcpi_rs2_o, b);
      chk({tag, "_iss_stall"}, 32'(stall_o), 32'd1);
      chk({tag, "_iss_rv"}, 32'(m_result_valid_o), 32'd0);
      step();
    end
    pcpi_ready_i = 1'b0; pcpi_rd_i = $urandom; pcpi_wr_i = 1'b0; ex_flush_i = fl_resp;
    settle();
    chk({tag, "_resp_rv"}, 32'(m_result_valid_o), 32'(!fl_resp));
    chk({tag, "_resp_res"}, m_result_o, exp);
    chk({tag, "_resp_rd"}, 32'(m_rd_o), 32'(rd));
    chk({tag, "_resp_we"}, 32'(m_we_o), 32'(wr && rd != 0 && !fl_resp));
    chk({tag, "_resp_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_resp_req"}, 32'(pcpi_valid_o), 32'd0);
    step();
    ex_valid_i = 1'b0; ex_flush_i = 1'b0;
  endtask

  task automatic idle_chk(input string tag, input logic [31:0] res, input logic [4:0] rd);
    ex_valid_i = 1'b0;
    settle();
    chk({tag, "_req"}, 32'(pcpi_valid_o), 32'd0);
    chk({tag, "_rv"}, 32'(m_result_valid_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_hold_res"}, m_result_o, res);
    chk({tag, "_hold_rd"}, 32'(m_rd_o), 32'(rd));
    step();
  endtask

  initial begin
    logic [31:0] spec_v [4];
    logic [31:0] ra, rb, ins;
    logic [2:0]  rf3;
    logic [4:0]  rrd;
    int          req0;
    spec_v = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};

    // Reset state.
    settle();
    chk_all_zero("reset");
    step();
    step();
    resetn = 1'b1;
    step();

    // MUL 7*6 -> x5.
    run_txn("mul", 3'd0, 32'd7, 32'd6, 5'd5, 2, 1'b1, 1'b0);
    idle_chk("mul_after", 32'd42, 5'd5);

    // Back-to-back DIV -5/2 then REMU 10/3: exactly two requests.
    req0 = req_cnt;
    run_txn("div", 3'd4, 32'hFFFF_FFFB, 32'd2, 5'd10, 1, 1'b1, 1'b0);
    run_txn("remu", 3'd7, 32'd10, 32'd3, 5'd11, 0, 1'b1, 1'b0);
    idle_chk("b2b_after", 32'd1, 5'd11);
    chk("b2b_req_count", 32'(req_cnt - req0), 32'd2);

    // Flush in ISSUE cycle 2, unit answers 3 cycles later.
    ins = enc(7'b0000001, 3'd0, 5'd7);
    ex_valid_i = 1'b1; ex_instr_i = ins; ex_rs1_i = 32'd3; ex_rs2_i = 32'd5;
    settle(); chk("fl_start_stall", 32'(stall_o), 32'd1); step();
    settle(); chk("fl_iss1_req", 32'(pcpi_valid_o), 32'd1); step();
    ex_flush_i = 1'b1;
    settle(); chk("fl_iss2_req", 32'(pcpi_valid_o), 32'd1); step();
    ex_flush_i = 1'b0; ex_instr_i = enc(7'b0000000, 3'd0, 5'd9);
    settle();
    chk("fl_drain_add_stall", 32'(stall_o), 32'd0);
    chk("fl_drain_req", 32'(pcpi_valid_o), 32'd1);
    chk("fl_drain_insn", pcpi_insn_o, ins);
    chk("fl_drain_rv", 32'(m_result_valid_o), 32'd0);
    step();
    ex_instr_i = enc(7'b0000001, 3'd3, 5'd12); ex_rs1_i = 32'hFFFF_FFFF; ex_rs2_i = 32'hFFFF_FFFF;
    settle(); chk("fl_drain_mulhu_stall", 32'(stall_o), 32'd1); step();
    pcpi_ready_i = 1'b1; pcpi_rd_i = 32'hDEAD_BEEF; pcpi_wr_i = 1'b1;
    settle();
    chk("fl_rdy_req", 32'(pcpi_valid_o), 32'd1);
    chk("fl_rdy_rs1", pcpi_rs1_o, 32'd3);
    chk("fl_rdy_rs2", pcpi_rs2_o, 32'd5);
    chk("fl_rdy_stall", 32'(stall_o), 32'd1);
    chk("fl_rdy_rv", 32'(m_result_valid_o), 32'd0);
    step();
    pcpi_ready_i = 1'b0;
    run_txn("fl_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1, 1'b1, 1'b0);

    // Flush coincident with ready, next M instruction issues right away.
    ex_valid_i = 1'b1; ex_instr_i = enc(7'b0000001, 3'd0, 5'd4);
    ex_rs1_i = 32'd9; ex_rs2_i = 32'd9;
    settle(); chk("flr_start_stall", 32'(stall_o), 32'd1); step();
    pcpi_ready_i = 1'b1; pcpi_rd_i = 32'd81; pcpi_wr_i = 1'b1; ex_flush_i = 1'b1;
    settle(); chk("flr_req", 32'(pcpi_valid_o), 32'd1); step();
    pcpi_ready_i = 1'b0; ex_flush_i = 1'b0;
    run_txn("flr_next", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 0, 1'b1, 1'b0);

    // rd = x0: result reported, no write.
    run_txn("mulh_x0", 3'd1, 32'h8000_0000, 32'd2, 5'd0, 1, 1'b1, 1'b0);
    idle_chk("mulh_x0_after", 32'hFFFF_FFFF, 5'd0);

    // Flush during RESP suppresses the writeback.
    run_txn("fl_resp", 3'd0, 32'd11, 32'd3, 5'd8, 0, 1'b1, 1'b1);

    // Non-M, flushed M and invalid M never start a request.
    ex_valid_i = 1'b1; ex_instr_i = enc(7'b0000000, 3'd0, 5'd3);
    settle(); chk("add_stall", 32'(stall_o), 32'd0); step();
    ex_instr_i = enc(7'b0000001, 3'd0, 5'd3); ex_flush_i = 1'b1;
    settle(); chk("flush_m_stall", 32'(stall_o), 32'd0);
    chk("add_no_req", 32'(pcpi_valid_o), 32'd0); step();
    ex_flush_i = 1'b0; ex_valid_i = 1'b0;
    settle(); chk("inval_m_stall", 32'(stall_o), 32'd0);
    chk("flush_m_no_req", 32'(pcpi_valid_o), 32'd0); step();

    // Randomized transactions against the reference model.
    for (int i = 0; i < 24; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
      rrd = 5'($urandom_range(0, 31));
      run_txn("rnd", rf3, ra, rb, rrd, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_chk("rnd_idle", mext(rf3, ra, rb), rrd);
    end

    // Asynchronous reset while a request is outstanding.
    ex_valid_i = 1'b1; ex_instr_i = enc(7'b0000001, 3'd5, 5'd13);
    ex_rs1_i = 32'd100; ex_rs2_i = 32'd7;
    step();
    settle(); chk("rst_iss_req", 32'(pcpi_valid_o), 32'd1);
    #2;
    resetn = 1'b0; ex_valid_i = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    resetn = 1'b1;
    pcpi_ready_i = 1'b1; pcpi_rd_i = 32'd14; pcpi_wr_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rst_after_req", 32'(pcpi_valid_o), 32'd0);
      chk("rst_after_rv", 32'(m_result_valid_o), 32'd0);
      step();
      pcpi_ready_i = 1'b0;
    end

    // Withheld ready: watchdog fires after 64 cycles when enabled, otherwise keeps waiting.
    ex_valid_i = 1'b1; ex_instr_i = enc(7'b0000001, 3'd0, 5'd3);
    ex_rs1_i = 32'd5; ex_rs2_i = 32'd5;
    step();
    for (int k = 0; k < 64; k++) begin
      settle();
      chk("wd_req", 32'(pcpi_valid_o), 32'd1);
      chk("wd_tmo_quiet", 32'(timeout_o), 32'd0);
      step();
    end
`ifdef M_PCPI_TIMEOUT_EN
    settle();
    chk("wd_tmo_pulse", 32'(timeout_o), 32'd1);
    chk("wd_rv", 32'(m_result_valid_o), 32'd1);
    chk("wd_we", 32'(m_we_o), 32'd0);
    chk("wd_res", m_result_o, 32'd0);
    chk("wd_req_drop", 32'(pcpi_valid_o), 32'd0);
    step();
    ex_valid_i = 1'b0;
    settle();
    chk("wd_tmo_end", 32'(timeout_o), 32'd0);
    step();
`else
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("wd_still_req", 32'(pcpi_valid_o), 32'd1);
      chk("wd_still_stall", 32'(stall_o), 32'd1);
      step();
    end
    pcpi_ready_i = 1'b1; pcpi_rd_i = 32'd25; pcpi_wr_i = 1'b1;
    step();
    pcpi_ready_i = 1'b0;
    settle();
    chk("wd_late_rv", 32'(m_result_valid_o), 32'd1);
    chk("wd_late_res", m_result_o, 32'd25);
    chk("wd_late_we", 32'(m_we_o), 32'd1);
    step();
    ex_valid_i = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
